pc_sequencer: RTL

- Program-counter sequencer for the 16-bit CPU.
- It is the consumer of the branch comparator's jump decision. Each accepted instruction either advances the PC or redirects it to a branch target.
- On a redirect it flushes the one wrong-path fetch already in flight.
- It drives the instruction-fetch address and qualifiers; the decode/execute stage feeds the branch qualifiers back.

---
 rtl/pc_sequencer_pkg.sv | 23 ++
 rtl/pc_sequencer_return_stack.sv | 49 ++++
 rtl/pc_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions: sequencer state encoding, default widths and reset PC,
// and the condition codes shared with the branch comparator.
package pc_sequencer_pkg;

  localparam int          ADDR_W_DEF   = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // Comparator condition codes; bit 3 selects the negated variant.
  localparam logic [3:0] CC_GT  = 4'b0000;
  localparam logic [3:0] CC_LT  = 4'b0001;
  localparam logic [3:0] CC_EQ  = 4'b0010;
  localparam logic [3:0] CC_NE  = 4'b0011;
  localparam logic [3:0] CC_Z   = 4'b0100;
  localparam logic [3:0] CC_NGT = 4'b1000;
  localparam logic [3:0] CC_NLT = 4'b1001;
  localparam logic [3:0] CC_NEQ = 4'b1010;
  localparam logic [3:0] CC_NNE = 4'b1011;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address LIFO; a push when full overwrites the oldest entry.
// Only built with PC_SEQUENCER_RETURN_STACK_EN defined.
`ifdef PC_SEQUENCER_RETURN_STACK_EN
module return_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         err
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] top_ptr;
  logic [CW-1:0] count;

  assign top_ptr = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - PW'(1);
  assign top     = mem[top_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign err     = (push && full) || (pop && empty);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - CW'(1);
    end
  end
endmodule
`endif

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: advances or redirects the fetch PC and flushes the
// single wrong-path fetch after a redirect. Optional return stack: PC_SEQUENCER_RETURN_STACK_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(RESET_PC_DEF),
  parameter int                STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_ready,
  input  logic              stall,
  input  logic              is_branch,
  input  logic              jump,
  input  logic              is_jmp,
  input  logic [ADDR_W-1:0] target,
  input  logic              halt_req,
  input  logic              is_call,
  input  logic              is_ret,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_en,
  output logic              flush,
  output logic              halted,
  output logic              stack_err,
  output logic [1:0]        fsm_state
);
  // Handshake: an instruction is consumed only on a cycle where instr_ready=1,
  // stall=0 and the sequencer is in RUN; all other cycles leave it unconsumed.
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [1:0]        state, state_n;
  logic [ADDR_W-1:0] pc_n, pc_inc;
  logic              err_n, accept, taken;

  assign fsm_state = state;
  assign accept    = instr_ready && !stall && (state == ST_RUN);
  assign taken     = is_jmp || (is_branch && jump);
  assign pc_inc    = pc + ONE;

`ifdef PC_SEQUENCER_RETURN_STACK_EN
  logic              do_push, do_pop, stk_full, stk_empty, stk_err;
  logic [ADDR_W-1:0] stk_top;
  logic              unused_stk;

  assign do_pop     = accept && !halt_req && is_ret;
  assign do_push    = accept && !halt_req && !is_ret && is_call;
  assign unused_stk = stk_full;

  return_stack #(.W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .err       (stk_err)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{is_call, is_ret, STACK_DEPTH[0]};
`endif

  always_comb begin
    state_n = state;
    pc_n    = pc;
    err_n   = 1'b0;
    case (state)
      ST_RUN: begin
        if (accept) begin
          if (halt_req) begin
            state_n = ST_HALT;
          end
`ifdef PC_SEQUENCER_RETURN_STACK_EN
          else if (is_ret) begin
            err_n = stk_err;
            if (stk_empty) begin
              pc_n = pc_inc;
            end else begin
              pc_n    = stk_top;
              state_n = ST_FLUSH;
            end
          end else if (is_call) begin
            err_n   = stk_err;
            pc_n    = target;
            state_n = ST_FLUSH;
          end
`endif
          else if (taken) begin
            pc_n    = target;
            state_n = ST_FLUSH;
          end else begin
            pc_n = pc_inc;
          end
        end
      end
      ST_FLUSH: begin
        if (!stall) state_n = ST_RUN;
      end
      default: state_n = state;
    endcase
  end

  // Outputs are registered copies of the next state so they line up with pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      pc        <= RESET_PC;
      fetch_en  <= 1'b0;
      flush     <= 1'b0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      fetch_en  <= (state_n != ST_HALT);
      flush     <= (state_n == ST_FLUSH);
      halted    <= (state_n == ST_HALT);
      stack_err <= err_n;
    end
  end

endmodule
